// File: rtl/spi_bridge_regbank_if.sv
`default_nettype none
// ============================================================================
// Interface : spi_bridge_regbank_if
// Purpose   : I2C-side register strobe bus plus SPI pins for spi_bridge_regbank
// Revision  : 1.0 - initial release
// ============================================================================
interface spi_bridge_regbank_if;
  logic       sram_cs;
  logic       sram_rw;
  logic [3:0] sram_addr;
  logic [7:0] sram_idata;
  logic [7:0] sram_odata;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  // master drives the register bus and plays the SPI device (miso)
  modport master (
    output sram_cs, sram_rw, sram_addr, sram_idata, spi_miso,
    input  sram_odata, spi_cs_n, spi_sclk, spi_mosi
  );

  modport slave (
    input  sram_cs, sram_rw, sram_addr, sram_idata, spi_miso,
    output sram_odata, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface
`default_nettype wire

// File: rtl/spi_bridge_regbank.sv
`default_nettype none
// ============================================================================
// Module   : spi_bridge_regbank
// Purpose  : 16-entry register bank behind an I2C slave, driving a mode-0
//            SPI master that shifts TXBUF out and captures into RXBUF
// Revision : 1.0 - initial release
// ============================================================================
module spi_bridge_regbank #(
  parameter logic [7:0] DIV_RST = 8'd4,
  parameter int         MAX_LEN = 8
) (
  input  wire logic           i_ck,
  input  wire logic           i_rst,
  spi_bridge_regbank_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    HOLD     = 3'd4,
    FIN      = 3'd5
  } state_t;

  localparam logic [3:0] c_max_len = (MAX_LEN >= 15) ? 4'd15 : 4'(MAX_LEN);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_txbuf [8];
  logic [7:0] r_rxbuf [4];
  logic [3:0] r_len;
  logic [7:0] r_div;
  logic       r_done, r_lenerr, r_ovr;
  logic [7:0] r_odata;

  logic [7:0] r_tcnt, w_tcnt_nxt;
  logic [7:0] r_div_lat, w_div_lat_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [3:0] r_byte, w_byte_nxt;
  logic [3:0] r_last, w_last_nxt;
  logic [7:0] r_tx, w_tx_nxt;
  logic [7:0] r_rx, w_rx_nxt;
  logic       r_sclk, r_cs_n;
  logic       w_rx_wr;

  logic       w_wr, w_rd, w_busy, w_tend;
  logic       w_start_req, w_start, w_lenerr_set;
  logic       w_cfg_wr, w_ovr_set, w_stat_wr;
  logic [3:0] w_len_eff, w_byte_inc;
  logic [7:0] w_rx_byte, w_rd_data;

  // ---------------------------------------------------------------- decode
  assign w_wr         = !bus.sram_cs && !bus.sram_rw;
  assign w_rd         = !bus.sram_cs &&  bus.sram_rw;
  assign w_busy       = (r_state != IDLE) && (r_state != FIN);
  assign w_start_req  = w_wr && (bus.sram_addr == 4'hE) && bus.sram_idata[0];
  assign w_start      = w_start_req && !w_busy && (r_len != 4'd0);
  assign w_lenerr_set = w_start_req && !w_busy && (r_len == 4'd0);
  assign w_cfg_wr     = w_wr && (!bus.sram_addr[3] || (bus.sram_addr == 4'hC) ||
                                 (bus.sram_addr == 4'hD));
  assign w_ovr_set    = w_cfg_wr && w_busy;
  assign w_stat_wr    = w_wr && (bus.sram_addr == 4'hF);
  assign w_len_eff    = (r_len > c_max_len) ? c_max_len : r_len;
  assign w_tend       = (r_tcnt == r_div_lat);
  assign w_byte_inc   = r_byte + 4'd1;
  // MISO enters the shift register on the first cycle of each high phase
  assign w_rx_byte    = (r_tcnt == 8'd0) ? {r_rx[6:0], bus.spi_miso} : r_rx;

  // ------------------------------------------------------------ FSM state
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_tcnt    <= 8'd0;
      r_div_lat <= 8'd0;
      r_bit     <= 3'd0;
      r_byte    <= 4'd0;
      r_last    <= 4'd0;
      r_tx      <= 8'd0;
      r_rx      <= 8'd0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_div_lat <= w_div_lat_nxt;
      r_bit     <= w_bit_nxt;
      r_byte    <= w_byte_nxt;
      r_last    <= w_last_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_sclk    <= (w_state_nxt == SHIFT_HI);
      r_cs_n    <= (w_state_nxt == IDLE) || (w_state_nxt == FIN);
    end
  end

  // ------------------------------------------------------- FSM next state
  always_comb begin
    w_state_nxt   = r_state;
    w_tcnt_nxt    = w_tend ? 8'd0 : r_tcnt + 8'd1;
    w_div_lat_nxt = r_div_lat;
    w_bit_nxt     = r_bit;
    w_byte_nxt    = r_byte;
    w_last_nxt    = r_last;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_rx_wr       = 1'b0;
    case (r_state)
      // BUSY is already low in FIN, so a START landing there is honoured
      IDLE, FIN: begin
        w_state_nxt = IDLE;
        w_tcnt_nxt  = 8'd0;
        w_tx_nxt    = 8'd0;
        if (w_start) begin
          w_state_nxt   = SETUP;
          w_div_lat_nxt = r_div;
          w_bit_nxt     = 3'd7;
          w_byte_nxt    = 4'd0;
          w_last_nxt    = w_len_eff - 4'd1;
          w_tx_nxt      = r_txbuf[0];
        end
      end
      SETUP: begin
        if (w_tend) w_state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (r_tcnt == 8'd0) w_rx_nxt = w_rx_byte;
        if (w_tend) begin
          if (r_bit != 3'd0) begin
            w_state_nxt = SHIFT_LO;
            w_bit_nxt   = r_bit - 3'd1;
            w_tx_nxt    = {r_tx[6:0], 1'b0};
          end else begin
            w_rx_wr = (r_byte < 4'd4);
            if (r_byte == r_last) begin
              w_state_nxt = HOLD;
            end else begin
              w_state_nxt = SHIFT_LO;
              w_byte_nxt  = w_byte_inc;
              w_bit_nxt   = 3'd7;
              w_tx_nxt    = r_txbuf[w_byte_inc[2:0]];
            end
          end
        end
      end
      SHIFT_LO: begin
        if (w_tend) w_state_nxt = SHIFT_HI;
      end
      HOLD: begin
        if (w_tend) w_state_nxt = FIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------- register bank
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) r_txbuf[i] <= 8'd0;
      for (int i = 0; i < 4; i++) r_rxbuf[i] <= 8'd0;
      r_len    <= 4'd0;
      r_div    <= DIV_RST;
      r_done   <= 1'b0;
      r_lenerr <= 1'b0;
      r_ovr    <= 1'b0;
      r_odata  <= 8'd0;
    end else begin
      if (w_wr && !w_busy) begin
        if (!bus.sram_addr[3])        r_txbuf[bus.sram_addr[2:0]] <= bus.sram_idata;
        if (bus.sram_addr == 4'hC)    r_len <= bus.sram_idata[3:0];
        if (bus.sram_addr == 4'hD)    r_div <= bus.sram_idata;
      end
      if (w_rx_wr) r_rxbuf[r_byte[1:0]] <= w_rx_byte;
      // sticky flags: a set in the same cycle as its W1C clear wins
      r_done   <= (r_state == FIN) || (r_done   && !(w_stat_wr && bus.sram_idata[1]));
      r_lenerr <= w_lenerr_set     || (r_lenerr && !(w_stat_wr && bus.sram_idata[2]));
      r_ovr    <= w_ovr_set        || (r_ovr    && !(w_stat_wr && bus.sram_idata[3]));
      if (w_rd) r_odata <= w_rd_data;
    end
  end

  always_comb begin
    w_rd_data = 8'd0;
    case (bus.sram_addr)
      4'h8, 4'h9, 4'hA, 4'hB: w_rd_data = r_rxbuf[bus.sram_addr[1:0]];
      4'hC:                   w_rd_data = {4'd0, r_len};
      4'hD:                   w_rd_data = r_div;
      4'hE:                   w_rd_data = 8'd0;
      4'hF:                   w_rd_data = {4'd0, r_ovr, r_lenerr, r_done, w_busy};
      default:                w_rd_data = r_txbuf[bus.sram_addr[2:0]];
    endcase
  end

  assign bus.sram_odata = r_odata;
  assign bus.spi_cs_n   = r_cs_n;
  assign bus.spi_sclk   = r_sclk;
  assign bus.spi_mosi   = r_tx[7];

endmodule
`default_nettype wire

// File: tb/tb_spi_bridge_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_bridge_regbank
// Purpose  : randomized self-checking bench for spi_bridge_regbank
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_bridge_regbank;
  localparam int         CP      = 10;
  localparam logic [7:0] DIV_RST = 8'd4;
  localparam int         MAX_LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(CP / 2) clk = ~clk;

  spi_bridge_regbank_if bus();

  spi_bridge_regbank #(.DIV_RST(DIV_RST), .MAX_LEN(MAX_LEN)) dut (
    .i_ck  (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------ SPI device side
  logic   loopback = 1'b0;
  logic   miso_bits [128];
  int     n_rise = 0, n_fall = 0, base_rise = 0, base_fall = 0;
  longint rise_t [4096];
  logic   mosi_at [4096];
  longint last_fall = 0, cs_rise = 0, cs_fall = 0;

  assign bus.spi_miso = loopback ? bus.spi_mosi : miso_bits[(n_fall - base_fall) % 128];

  always @(posedge bus.spi_sclk) begin
    if (n_rise < 4096) begin
      rise_t[n_rise]  = $time;
      mosi_at[n_rise] = bus.spi_mosi;
    end
    n_rise++;
  end
  always @(negedge bus.spi_sclk) begin
    last_fall = $time;
    n_fall++;
  end
  always @(posedge bus.spi_cs_n) cs_rise = $time;
  always @(negedge bus.spi_cs_n) cs_fall = $time;

  // ------------------------------------------------------ reference model
  logic [7:0] m_tx [8];
  logic [7:0] m_rx [4];
  logic [3:0] m_len;
  logic [7:0] m_div;
  logic       m_done, m_lenerr, m_ovr;
  int         n_exp, xmode;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_tx[i] = 8'd0;
    for (int i = 0; i < 4; i++) m_rx[i] = 8'd0;
    m_len = 4'd0; m_div = DIV_RST;
    m_done = 1'b0; m_lenerr = 1'b0; m_ovr = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (a < 4'h8)  return m_tx[a[2:0]];
    if (a < 4'hC)  return m_rx[a[1:0]];
    if (a == 4'hC) return {4'd0, m_len};
    if (a == 4'hD) return m_div;
    if (a == 4'hE) return 8'd0;
    return {4'd0, m_ovr, m_lenerr, m_done, 1'b0};
  endfunction

  // byte the SPI device returns in slot b of the current transfer
  function automatic logic [7:0] src_byte(input int b);
    logic [7:0] v;
    if (xmode == 2) return m_tx[b];
    for (int j = 0; j < 8; j++) v[7-j] = miso_bits[b*8 + j];
    return v;
  endfunction

  // ---------------------------------------------------- register bus ops
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.sram_cs = 1'b0; bus.sram_rw = 1'b0; bus.sram_addr = a; bus.sram_idata = d;
    @(negedge clk);
    bus.sram_cs = 1'b1; bus.sram_rw = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus.sram_cs = 1'b0; bus.sram_rw = 1'b1; bus.sram_addr = a;
    @(negedge clk);
    bus.sram_cs = 1'b1;
    d = bus.sram_odata;
  endtask

  task automatic rd_chk(input logic [3:0] a, input string tag);
    logic [7:0] v;
    rd(a, v);
    check($sformatf("%s@%0h", tag, a), v, m_read(a));
  endtask

  // idle-time write with model update
  task automatic mwr(input logic [3:0] a, input logic [7:0] d);
    wr(a, d);
    if (a < 4'h8)       m_tx[a[2:0]] = d;
    else if (a == 4'hC) m_len = d[3:0];
    else if (a == 4'hD) m_div = d;
    else if (a == 4'hF) begin
      if (d[1]) m_done = 1'b0;
      if (d[2]) m_lenerr = 1'b0;
      if (d[3]) m_ovr = 1'b0;
    end
  endtask

  // ------------------------------------------------------ transfer tasks
  // mode 0: random MISO, 1: MISO tied high, 2: MOSI looped back
  task automatic xfer_begin(input int md);
    logic [7:0] v;
    xmode    = md;
    loopback = (md == 2);
    for (int i = 0; i < 128; i++) miso_bits[i] = (md == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    base_rise = n_rise; base_fall = n_fall;
    n_exp = (int'(m_len) > MAX_LEN) ? MAX_LEN : int'(m_len);
    wr(4'hE, 8'h01);
    check("start_cs_low", bus.spi_cs_n, 1'b0);
    rd(4'hF, v);
    check("status_busy", v, {4'd0, m_ovr, m_lenerr, m_done, 1'b1});
  endtask

  task automatic xfer_end(input bit w1c_in_fin);
    longint t;
    int     cnt, perr, k;
    logic [7:0] b;
    t = (longint'(m_div) + 1) * CP;
    for (k = 0; k < 4000 && !bus.spi_cs_n; k++) @(negedge clk);
    check("xfer_done", bus.spi_cs_n, 1'b1);
    if (w1c_in_fin) wr(4'hF, 8'h02);
    else            @(negedge clk);
    m_done = 1'b1;
    for (int bi = 0; bi < n_exp && bi < 4; bi++) m_rx[bi] = src_byte(bi);
    cnt = n_rise - base_rise;
    check("sclk_edges", cnt, 8 * n_exp);
    for (int bi = 0; bi < n_exp; bi++) begin
      for (int j = 0; j < 8; j++) b[7-j] = mosi_at[(base_rise + bi*8 + j) % 4096];
      check($sformatf("mosi_byte%0d", bi), b, m_tx[bi]);
    end
    perr = 0;
    for (int i = 1; i < cnt && i < 8 * n_exp; i++)
      if (rise_t[(base_rise + i) % 4096] - rise_t[(base_rise + i - 1) % 4096] != 2 * t) perr++;
    check("sclk_period", perr, 0);
    check("setup_time", rise_t[base_rise % 4096] - cs_fall, t);
    check("hold_time", cs_rise - last_fall, t);
    loopback = 1'b0;
    for (int a = 8; a < 12; a++) rd_chk(4'(a), "rxbuf");
    rd_chk(4'hF, "status_after");
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    logic [3:0] a;
    logic [7:0] v;
    int         lows, k, r0;
    bus.sram_cs = 1'b1; bus.sram_rw = 1'b1; bus.sram_addr = 4'd0; bus.sram_idata = 8'd0;
    for (int i = 0; i < 128; i++) miso_bits[i] = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_cs_n", bus.spi_cs_n, 1'b1);
    check("rst_sclk", bus.spi_sclk, 1'b0);
    check("rst_mosi", bus.spi_mosi, 1'b0);
    check("rst_odata", bus.sram_odata, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic access
    mwr(4'h3, 8'h5A);
    rd_chk(4'h3, "txbuf_rw");
    rd_chk(4'hE, "ctrl_reads0");
    rd_chk(4'hD, "div_rst");
    rd_chk(4'hF, "status_rst");

    // random register traffic, including ignored RXBUF writes
    for (int i = 0; i < 16; i++) begin
      a = 4'($urandom_range(0, 13));
      mwr(a, 8'($urandom));
      rd_chk(a, "rand_rw");
    end

    // single byte, DIV=0, loopback
    mwr(4'h0, 8'hA5); mwr(4'hC, 8'h01); mwr(4'hD, 8'h00);
    xfer_begin(2);
    xfer_end(1'b0);

    // six bytes with MISO high; nothing beyond RXBUF[3] may change
    mwr(4'hC, 8'h06); mwr(4'hD, 8'($urandom_range(0, 3)));
    xfer_begin(1);
    xfer_end(1'b0);
    for (int i = 0; i < 8; i++) rd_chk(4'(i), "txbuf_kept");
    rd_chk(4'hC, "len_kept");
    rd_chk(4'hD, "div_kept");

    // random transfers, LEN up to 15 exercises the MAX_LEN clamp
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) mwr(4'(i), 8'($urandom));
      mwr(4'hC, 8'($urandom_range(1, 15)));
      mwr(4'hD, 8'($urandom_range(0, 3)));
      mwr(4'hF, 8'h0E);
      xfer_begin($urandom_range(0, 2));
      xfer_end(1'b0);
    end

    // error flags
    mwr(4'hC, 8'h00);
    wr(4'hE, 8'h01);
    m_lenerr = 1'b1;
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      if (!bus.spi_cs_n) lows++;
      @(negedge clk);
    end
    check("lenerr_no_cs", lows, 0);
    rd_chk(4'hF, "lenerr_flag");
    mwr(4'hC, 8'h02); mwr(4'hD, 8'h03);
    xfer_begin(0);
    wr(4'h0, ~m_tx[0]);
    m_ovr = 1'b1;
    wr(4'hE, 8'h01);
    rd(4'hF, v);
    check("ovr_busy", v, {4'd0, m_ovr, m_lenerr, m_done, 1'b1});
    xfer_end(1'b0);
    rd_chk(4'h0, "txbuf_busy_kept");
    mwr(4'hF, 8'h0E);
    rd_chk(4'hF, "w1c_clear");

    // W1C of DONE in the FIN cycle loses to the set
    mwr(4'hC, 8'h01); mwr(4'hD, 8'h00);
    xfer_begin(2);
    xfer_end(1'b1);

    // abort in the third byte of a 4-byte transfer, then restart
    for (int i = 0; i < 8; i++) mwr(4'(i), 8'($urandom));
    mwr(4'hC, 8'h04); mwr(4'hD, 8'h01); mwr(4'hF, 8'h0E);
    xfer_begin(0);
    for (k = 0; k < 2000 && (n_rise - base_rise) < 17; k++) @(negedge clk);
    check("abort_reach", n_rise - base_rise, 17);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", bus.spi_cs_n, 1'b1);
    check("abort_sclk", bus.spi_sclk, 1'b0);
    check("abort_mosi", bus.spi_mosi, 1'b0);
    check("abort_odata", bus.sram_odata, 8'd0);
    rst = 1'b0;
    loopback = 1'b0;
    m_reset();
    r0 = n_rise;
    rd_chk(4'hF, "abort_status");
    rd_chk(4'hD, "abort_div");
    rd_chk(4'h8, "abort_rx");
    rd_chk(4'h2, "abort_tx");
    check("abort_quiet", n_rise - r0, 0);
    for (int i = 0; i < 4; i++) mwr(4'(i), 8'($urandom));
    mwr(4'hC, 8'h03); mwr(4'hD, 8'($urandom_range(0, 2)));
    xfer_begin(0);
    xfer_end(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #(CP * 60000);
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
